// File: rtl/lsu_dcache_arbiter_pkg.sv
// Shared types and tag helpers for the LSU/prefetch dcache arbiter.
// Tag layout on the dcache side is {orig_tag, requester_sel}.
package lsu_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] tag_pack(
    input logic [63:0] tag,
    input logic [31:0] sel,
    input int          sw
  );
    logic [63:0] m;
    m = (64'd1 << sw) - 64'd1;
    return (tag << sw) | ({32'd0, sel} & m);
  endfunction

  function automatic logic [31:0] tag_sel(
    input logic [63:0] t,
    input int          sw
  );
    logic [63:0] m;
    m = (64'd1 << sw) - 64'd1;
    return 32'(t & m);
  endfunction

  function automatic logic [63:0] tag_orig(
    input logic [63:0] t,
    input int          sw
  );
    return t >> sw;
  endfunction

endpackage

// File: rtl/lsu_dcache_arbiter_if.sv
// Requester-side and dcache-side buses of the arbiter.
// slave = arbiter view, master = surrounding core view.
interface lsu_dcache_arbiter_if
  import lsu_arb_pkg::*;
#(
  parameter int NUM_REQS    = 2,
  parameter int NUM_THREADS = 4,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int TAG_IN_W    = 8,
  parameter int REQ_SEL_W   = sel_w(NUM_REQS),
  parameter int TAG_OUT_W   = TAG_IN_W + REQ_SEL_W
) ();
  localparam int NR = NUM_REQS;
  localparam int NT = NUM_THREADS;

  logic [NR*NT-1:0]          req_valid_in;
  logic [NR*NT-1:0]          req_rw_in;
  logic [NR*NT*4-1:0]        req_byteen_in;
  logic [NR*NT*ADDR_W-1:0]   req_addr_in;
  logic [NR*NT*DATA_W-1:0]   req_data_in;
  logic [NR*NT*TAG_IN_W-1:0] req_tag_in;
  logic [NR*NT-1:0]          req_ready_out;

  logic [NT-1:0]             dc_req_valid;
  logic [NT-1:0]             dc_req_rw;
  logic [NT*4-1:0]           dc_req_byteen;
  logic [NT*ADDR_W-1:0]      dc_req_addr;
  logic [NT*DATA_W-1:0]      dc_req_data;
  logic [NT*TAG_OUT_W-1:0]   dc_req_tag;
  logic [NT-1:0]             dc_req_ready;

  logic                      dc_rsp_valid;
  logic [NT-1:0]             dc_rsp_tmask;
  logic [NT*DATA_W-1:0]      dc_rsp_data;
  logic [TAG_OUT_W-1:0]      dc_rsp_tag;
  logic                      dc_rsp_ready;

  logic [NR-1:0]             rsp_valid_out;
  logic [NT-1:0]             rsp_tmask_out;
  logic [NT*DATA_W-1:0]      rsp_data_out;
  logic [TAG_IN_W-1:0]       rsp_tag_out;
  logic [NR-1:0]             rsp_ready_in;

  modport slave (
    input  req_valid_in, req_rw_in, req_byteen_in,
    input  req_addr_in, req_data_in, req_tag_in,
    output req_ready_out,
    output dc_req_valid, dc_req_rw, dc_req_byteen,
    output dc_req_addr, dc_req_data, dc_req_tag,
    input  dc_req_ready,
    input  dc_rsp_valid, dc_rsp_tmask, dc_rsp_data,
    input  dc_rsp_tag,
    output dc_rsp_ready,
    output rsp_valid_out, rsp_tmask_out, rsp_data_out,
    output rsp_tag_out,
    input  rsp_ready_in
  );

  modport master (
    output req_valid_in, req_rw_in, req_byteen_in,
    output req_addr_in, req_data_in, req_tag_in,
    input  req_ready_out,
    input  dc_req_valid, dc_req_rw, dc_req_byteen,
    input  dc_req_addr, dc_req_data, dc_req_tag,
    output dc_req_ready,
    output dc_rsp_valid, dc_rsp_tmask, dc_rsp_data,
    output dc_rsp_tag,
    input  dc_rsp_ready,
    input  rsp_valid_out, rsp_tmask_out, rsp_data_out,
    input  rsp_tag_out,
    output rsp_ready_in
  );
endinterface

// File: rtl/lsu_dcache_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first active request
// at or after rr_ptr wins.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] reqs,
  input  logic [W-1:0] rr_ptr,
  output logic [N-1:0] grant_oh,
  output logic [W-1:0] grant_idx,
  output logic         grant_any
);
  always_comb begin
    logic [W-1:0] j;
    j         = '0;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(rr_ptr) + k) % N);
      if (!grant_any && reqs[j]) begin
        grant_any   = 1'b1;
        grant_oh[j] = 1'b1;
        grant_idx   = j;
      end
    end
  end
endmodule

// File: rtl/lsu_dcache_arbiter.sv
// Shares the dcache port between LSU and prefetcher, one whole
// multi-lane request at a time. Optional counters: LSU_ARB_PERF_EN.
module lsu_dcache_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int NUM_REQS    = 2,
  parameter int NUM_THREADS = 4,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int TAG_IN_W    = 8,
  parameter int REQ_SEL_W   = sel_w(NUM_REQS),
  parameter int TAG_OUT_W   = TAG_IN_W + REQ_SEL_W
) (
  input  logic clk,
  input  logic reset,
  lsu_dcache_arbiter_if.slave bus
`ifdef LSU_ARB_PERF_EN
  ,
  output logic [NUM_REQS*32-1:0] perf_stall_cycles,
  output logic [NUM_REQS*32-1:0] perf_grants
`endif
);
  localparam int NR = NUM_REQS;
  localparam int NT = NUM_THREADS;
  localparam int SW = REQ_SEL_W;
  localparam logic [0:0] S_IDLE   = ARB_IDLE;
  localparam logic [0:0] S_LOCKED = ARB_LOCKED;

  logic [0:0]    state;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] grant_q;
  logic [NT-1:0] sent_mask;

  logic [NR-1:0] active;
  logic [NR-1:0] pick_oh;
  logic [SW-1:0] pick_idx;
  logic          pick_any;

  logic          locked;
  logic          grant_live;
  logic [NR-1:0] grant_oh;
  logic [SW-1:0] cur;
  logic [NT-1:0] gvalid;
  logic [NT-1:0] fired;
  logic          done;

  function automatic logic [SW-1:0] rr_next(input logic [SW-1:0] x);
    return (int'(x) == NR - 1) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    active = '0;
    for (int r = 0; r < NR; r++)
      active[r] = |bus.req_valid_in[r*NT +: NT];
  end

  rr_arbiter #(.N(NR), .W(SW)) u_rr (
    .reqs      (active),
    .rr_ptr    (rr_ptr),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  // Zero-latency grant in IDLE; frozen on grant_q once locked.
  assign locked     = (state == S_LOCKED);
  assign grant_live = locked | pick_any;
  assign cur        = locked ? grant_q : pick_idx;
  assign grant_oh   = locked ? NR'(1) << grant_q : pick_oh;

  assign gvalid = bus.req_valid_in[int'(cur)*NT +: NT];
  assign fired  = bus.dc_req_valid & bus.dc_req_ready;
  assign done   = &(sent_mask | fired | ~gvalid);

  always_comb begin
    bus.dc_req_valid  = gvalid & ~sent_mask;
    bus.dc_req_rw     = bus.req_rw_in[int'(cur)*NT +: NT];
    bus.dc_req_byteen = bus.req_byteen_in[int'(cur)*NT*4 +: NT*4];
    bus.dc_req_addr   =
      bus.req_addr_in[int'(cur)*NT*ADDR_W +: NT*ADDR_W];
    bus.dc_req_data   =
      bus.req_data_in[int'(cur)*NT*DATA_W +: NT*DATA_W];
    bus.dc_req_tag    = '0;
    for (int i = 0; i < NT; i++)
      bus.dc_req_tag[i*TAG_OUT_W +: TAG_OUT_W] = TAG_OUT_W'(tag_pack(
        64'(bus.req_tag_in[(int'(cur)*NT+i)*TAG_IN_W +: TAG_IN_W]),
        32'(cur), SW));
  end

  always_comb begin
    bus.req_ready_out = '0;
    for (int r = 0; r < NR; r++)
      if (grant_oh[r])
        bus.req_ready_out[r*NT +: NT] = bus.dc_req_ready & ~sent_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_q   <= '0;
      sent_mask <= '0;
    end else if (!locked) begin
      if (pick_any) begin
        if (done) begin
          rr_ptr <= rr_next(pick_idx);
        end else begin
          state     <= S_LOCKED;
          grant_q   <= pick_idx;
          sent_mask <= fired;
        end
      end
    end else if (done) begin
      state     <= S_IDLE;
      sent_mask <= '0;
      rr_ptr    <= rr_next(grant_q);
    end else begin
      sent_mask <= sent_mask | fired;
    end
  end

  logic [SW-1:0] rsp_sel;
  logic          rsp_in_range;

  assign rsp_sel      = SW'(tag_sel(64'(bus.dc_rsp_tag), SW));
  assign rsp_in_range = (32'(rsp_sel) < 32'(NR));

  always_comb begin
    bus.rsp_valid_out = '0;
    if (rsp_in_range)
      bus.rsp_valid_out[rsp_sel] = bus.dc_rsp_valid;
  end

  // Stray selects are swallowed so the dcache never wedges.
  assign bus.dc_rsp_ready  =
    rsp_in_range ? bus.rsp_ready_in[rsp_sel] : 1'b1;
  assign bus.rsp_tmask_out = bus.dc_rsp_tmask;
  assign bus.rsp_data_out  = bus.dc_rsp_data;
  assign bus.rsp_tag_out   =
    TAG_IN_W'(tag_orig(64'(bus.dc_rsp_tag), SW));

  a_rsp_sel: assert property (
    @(posedge clk) disable iff (reset)
    bus.dc_rsp_valid |-> rsp_in_range);

`ifdef LSU_ARB_PERF_EN
  logic [31:0] stall_q [NR];
  logic [31:0] grant_cnt_q [NR];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NR; r++) begin
        stall_q[r]     <= '0;
        grant_cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (active[r] && !grant_oh[r] && stall_q[r] != '1)
          stall_q[r] <= stall_q[r] + 32'd1;
        if (grant_live && done && grant_oh[r] &&
            grant_cnt_q[r] != '1)
          grant_cnt_q[r] <= grant_cnt_q[r] + 32'd1;
      end
    end
  end

  always_comb begin
    perf_stall_cycles = '0;
    perf_grants       = '0;
    for (int r = 0; r < NR; r++) begin
      perf_stall_cycles[r*32 +: 32] = stall_q[r];
      perf_grants[r*32 +: 32]       = grant_cnt_q[r];
    end
  end
`endif

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// Directed-vector bench for lsu_dcache_arbiter (2 requesters, 4 lanes).
// Inputs change on negedge; outputs are checked 1ns later.
module tb_lsu_dcache_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  lsu_dcache_arbiter_if bus ();

`ifdef LSU_ARB_PERF_EN
  logic [63:0] perf_stall_cycles;
  logic [63:0] perf_grants;
`endif

  lsu_dcache_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef LSU_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_grants       (perf_grants)
`endif
  );

  task automatic clear_inputs();
    bus.req_valid_in  = '0;
    bus.req_rw_in     = '0;
    bus.req_byteen_in = '0;
    bus.req_addr_in   = '0;
    bus.req_data_in   = '0;
    bus.req_tag_in    = '0;
    bus.dc_req_ready  = '0;
    bus.dc_rsp_valid  = 1'b0;
    bus.dc_rsp_tmask  = '0;
    bus.dc_rsp_data   = '0;
    bus.dc_rsp_tag    = '0;
    bus.rsp_ready_in  = '0;
  endtask

  // Payload of requester r lane i is a fixed function of (r, i).
  task automatic set_req(input int r, input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      bus.req_valid_in[r*4+i]         = v[i];
      bus.req_rw_in[r*4+i]            = (r == 1);
      bus.req_byteen_in[(r*4+i)*4 +: 4] = 4'hF;
      bus.req_addr_in[(r*4+i)*30 +: 30] = 30'(32'h100 * r + i);
      bus.req_data_in[(r*4+i)*32 +: 32] =
        32'hD000_0000 | 32'(r << 8) | 32'(i);
      bus.req_tag_in[(r*4+i)*8 +: 8]  = 8'(8'h40 + 16 * r + i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    nvec++;
    if (bus.dc_req_valid !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_dc_valid got=%b exp=%b",
               bus.dc_req_valid, 4'b0000);
    end
    nvec++;
    if (bus.req_ready_out !== 8'h00) begin
      nerr++;
      $display("FAIL reset_req_ready got=%h exp=%h",
               bus.req_ready_out, 8'h00);
    end
    nvec++;
    if (bus.rsp_valid_out !== 2'b00) begin
      nerr++;
      $display("FAIL reset_rsp_valid got=%b exp=%b",
               bus.rsp_valid_out, 2'b00);
    end
    nvec++;
    if (bus.dc_rsp_ready !== 1'b0) begin
      nerr++;
      $display("FAIL reset_dc_rsp_ready got=%b exp=0",
               bus.dc_rsp_ready);
    end
  endtask

  task automatic test_single();
    logic [35:0]  exp_tag;
    logic [119:0] exp_addr;
    exp_tag  = '0;
    exp_addr = '0;
    for (int i = 0; i < 4; i++) begin
      exp_tag[i*9 +: 9]    = {8'(8'h40 + i), 1'b0};
      exp_addr[i*30 +: 30] = 30'(i);
    end
    @(negedge clk);
    set_req(0, 4'b1111);
    bus.dc_req_ready = 4'b1111;
    #1;
    nvec++;
    if (bus.dc_req_valid !== 4'b1111) begin
      nerr++;
      $display("FAIL single_valid got=%b exp=%b",
               bus.dc_req_valid, 4'b1111);
    end
    nvec++;
    if (bus.req_ready_out !== 8'h0F) begin
      nerr++;
      $display("FAIL single_ready got=%h exp=%h",
               bus.req_ready_out, 8'h0F);
    end
    nvec++;
    if (bus.dc_req_tag !== exp_tag) begin
      nerr++;
      $display("FAIL single_tag got=%h exp=%h",
               bus.dc_req_tag, exp_tag);
    end
    nvec++;
    if (bus.dc_req_addr !== exp_addr) begin
      nerr++;
      $display("FAIL single_addr got=%h exp=%h",
               bus.dc_req_addr, exp_addr);
    end
    // rr_ptr is now 1 and state IDLE: r1 must win next.
    @(negedge clk);
    set_req(1, 4'b1111);
    #1;
    nvec++;
    if (bus.req_ready_out !== 8'hF0) begin
      nerr++;
      $display("FAIL single_rr_next got=%h exp=%h",
               bus.req_ready_out, 8'hF0);
    end
  endtask

  task automatic test_alternation();
    logic [7:0]  exp_rdy [3];
    logic [31:0] exp_d0  [3];
    exp_rdy[0] = 8'h0F; exp_d0[0] = 32'hD000_0000;
    exp_rdy[1] = 8'hF0; exp_d0[1] = 32'hD000_0100;
    exp_rdy[2] = 8'h0F; exp_d0[2] = 32'hD000_0000;
    do_reset();
    set_req(0, 4'b1111);
    set_req(1, 4'b1111);
    bus.dc_req_ready = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      nvec++;
      if (bus.req_ready_out !== exp_rdy[c]) begin
        nerr++;
        $display("FAIL alt_ready cyc=%0d got=%h exp=%h",
                 c, bus.req_ready_out, exp_rdy[c]);
      end
      nvec++;
      if (bus.dc_req_data[31:0] !== exp_d0[c]) begin
        nerr++;
        $display("FAIL alt_data cyc=%0d got=%h exp=%h",
                 c, bus.dc_req_data[31:0], exp_d0[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_partial();
    do_reset();
    set_req(0, 4'b1111);
    set_req(1, 4'b1111);
    bus.dc_req_ready = 4'b0011;
    #1;
    nvec++;
    if (bus.dc_req_valid !== 4'b1111) begin
      nerr++;
      $display("FAIL part_c0_valid got=%b exp=%b",
               bus.dc_req_valid, 4'b1111);
    end
    nvec++;
    if (bus.req_ready_out !== 8'h03) begin
      nerr++;
      $display("FAIL part_c0_ready got=%h exp=%h",
               bus.req_ready_out, 8'h03);
    end
    @(negedge clk);
    bus.dc_req_ready = 4'b1100;
    #1;
    nvec++;
    if (bus.dc_req_valid !== 4'b1100) begin
      nerr++;
      $display("FAIL part_c1_valid got=%b exp=%b",
               bus.dc_req_valid, 4'b1100);
    end
    nvec++;
    if (bus.req_ready_out !== 8'h0C) begin
      nerr++;
      $display("FAIL part_c1_ready got=%h exp=%h",
               bus.req_ready_out, 8'h0C);
    end
    @(negedge clk);
    bus.dc_req_ready = 4'b1111;
    #1;
    nvec++;
    if (bus.req_ready_out !== 8'hF0) begin
      nerr++;
      $display("FAIL part_c2_ready got=%h exp=%h",
               bus.req_ready_out, 8'hF0);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_response();
    logic [2:0] rv [4];
    logic [8:0] tg [4];
    logic [1:0] rr [4];
    logic [1:0] ev [4];
    logic [7:0] et [4];
    logic       er [4];
    rv[0] = 1; tg[0] = {8'h5A, 1'b1}; rr[0] = 2'b10;
    ev[0] = 2'b10; et[0] = 8'h5A; er[0] = 1'b1;
    rv[1] = 1; tg[1] = {8'h5A, 1'b1}; rr[1] = 2'b01;
    ev[1] = 2'b10; et[1] = 8'h5A; er[1] = 1'b0;
    rv[2] = 1; tg[2] = {8'hC3, 1'b0}; rr[2] = 2'b01;
    ev[2] = 2'b01; et[2] = 8'hC3; er[2] = 1'b1;
    rv[3] = 0; tg[3] = {8'h11, 1'b0}; rr[3] = 2'b10;
    ev[3] = 2'b00; et[3] = 8'h11; er[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.dc_rsp_valid = rv[k][0];
      bus.dc_rsp_tag   = tg[k];
      bus.dc_rsp_tmask = 4'b1010;
      bus.dc_rsp_data  = 128'h1234 + 128'(k);
      bus.rsp_ready_in = rr[k];
      #1;
      nvec++;
      if (bus.rsp_valid_out !== ev[k] ||
          bus.rsp_tag_out !== et[k] ||
          bus.dc_rsp_ready !== er[k]) begin
        nerr++;
        $display("FAIL rsp%0d got v=%b t=%h r=%b exp v=%b t=%h r=%b",
                 k, bus.rsp_valid_out, bus.rsp_tag_out,
                 bus.dc_rsp_ready, ev[k], et[k], er[k]);
      end
      nvec++;
      if (bus.rsp_data_out !== 128'h1234 + 128'(k) ||
          bus.rsp_tmask_out !== 4'b1010) begin
        nerr++;
        $display("FAIL rsp_pass%0d got d=%h m=%b exp d=%h m=%b",
                 k, bus.rsp_data_out, bus.rsp_tmask_out,
                 128'h1234 + 128'(k), 4'b1010);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_locked();
    do_reset();
    set_req(0, 4'b1111);
    bus.dc_req_ready = 4'b0001;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    #1;
    nvec++;
    if (bus.dc_req_valid !== 4'b0000) begin
      nerr++;
      $display("FAIL rstlock_idle got=%b exp=%b",
               bus.dc_req_valid, 4'b0000);
    end
    set_req(0, 4'b1111);
    set_req(1, 4'b1111);
    bus.dc_req_ready = 4'b1111;
    #1;
    nvec++;
    if (bus.dc_req_valid !== 4'b1111) begin
      nerr++;
      $display("FAIL rstlock_valid got=%b exp=%b",
               bus.dc_req_valid, 4'b1111);
    end
    nvec++;
    if (bus.req_ready_out !== 8'h0F) begin
      nerr++;
      $display("FAIL rstlock_ready got=%h exp=%h",
               bus.req_ready_out, 8'h0F);
    end
    @(negedge clk);
    clear_inputs();
  endtask

`ifdef LSU_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    set_req(0, 4'b1111);
    @(negedge clk);
    set_req(1, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    bus.dc_req_ready = 4'b1111;
    @(negedge clk);
    clear_inputs();
    #1;
    nvec++;
    if (perf_stall_cycles[63:32] !== 32'd3) begin
      nerr++;
      $display("FAIL perf_stall1 got=%0d exp=3",
               perf_stall_cycles[63:32]);
    end
    nvec++;
    if (perf_stall_cycles[31:0] !== 32'd0) begin
      nerr++;
      $display("FAIL perf_stall0 got=%0d exp=0",
               perf_stall_cycles[31:0]);
    end
    nvec++;
    if (perf_grants[31:0] !== 32'd1) begin
      nerr++;
      $display("FAIL perf_grants0 got=%0d exp=1",
               perf_grants[31:0]);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_alternation();
    test_partial();
    test_response();
    test_reset_locked();
`ifdef LSU_ARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
